// File: rtl/mux_arb_pkg.sv
// Shared mode encoding and select-width derivation for the mux/arbiter/register block.
package mux_arb_pkg;

   typedef enum logic {
      MODE_SELECT = 1'b0,
      MODE_RR     = 1'b1
   } mode_e;

   // Channel-index width; a 1- or 2-channel mux still needs one select bit.
   function automatic int sw_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester after ptr, wrapping modulo N.
module rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int  N  = 4,
   localparam int SW = sw_of(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [SW-1:0] grant,
   output logic          grant_valid
);

   always_comb begin
      grant       = '0;
      grant_valid = |req;
      // Walk from farthest to nearest so the closest requester after ptr wins.
      for (int k = N; k >= 1; k--) begin
         if (req[(int'(ptr) + k) % N])
            grant = SW'((int'(ptr) + k) % N);
      end
   end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel mux with SELECT / round-robin arbitration feeding a single output register.
module mux_arb_reg
   import mux_arb_pkg::*;
#(
   parameter int  N  = 4,
   parameter int  W  = 8,
   localparam int SW = sw_of(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   in_valid,
   input  logic [N*W-1:0] in_data,
   output logic [N-1:0]   in_ready,
   input  logic           mode,
   input  logic [SW-1:0]  sel,
   output logic           out_valid,
   output logic [W-1:0]   out_data,
   output logic [SW-1:0]  out_chan,
   input  logic           out_ready
);

   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q,  out_data_d;
   logic [SW-1:0] out_chan_q,  out_chan_d;
   logic [SW-1:0] ptr_q,       ptr_d;

   logic [SW-1:0] rr_grant;
   logic          rr_grant_valid;
   logic [SW-1:0] grant;
   logic          grant_valid;
   logic [N-1:0]  vld_shift;
   logic          load_en;
   logic          in_xfer;

   rr_arbiter #(.N(N)) u_rr (
      .req         (in_valid),
      .ptr         (ptr_q),
      .grant       (rr_grant),
      .grant_valid (rr_grant_valid)
   );

   assign load_en   = !out_valid_q || out_ready;
   assign vld_shift = in_valid >> sel;

   always_comb begin
      if (mode_e'(mode) == MODE_RR) begin
         grant       = rr_grant;
         grant_valid = rr_grant_valid;
      end else begin
         grant       = sel;
         grant_valid = (int'(sel) < N) && vld_shift[0];
      end
   end

   always_comb begin
      in_ready = '0;
      if (load_en && grant_valid && !rst)
         in_ready[grant] = 1'b1;
   end

   assign in_xfer = |(in_valid & in_ready);

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      // An empty load slot drops valid but keeps the last word visible.
      if (load_en) begin
         out_valid_d = in_xfer;
         if (in_xfer) begin
            out_data_d = in_data[int'(grant)*W +: W];
            out_chan_d = grant;
            ptr_d      = grant;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= SW'(N - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule
